// File: rtl/quad_step_pkg.sv
// Shared types and Gray-code helpers for the quadrature step decoder.
// Phase pairs are packed {A, B}; the forward order is 00 -> 10 -> 11 -> 01 -> 00.
package quad_step_pkg;

    typedef logic [1:0] quad_phase_t;

    localparam quad_phase_t PH_00 = 2'b00;
    localparam quad_phase_t PH_10 = 2'b10;
    localparam quad_phase_t PH_11 = 2'b11;
    localparam quad_phase_t PH_01 = 2'b01;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_FWD,
        DIR_REV,
        DIR_ILLEGAL
    } quad_dir_t;

    function automatic quad_phase_t quad_fwd_next(quad_phase_t p);
        quad_phase_t n;
        n = PH_00;
        unique case (p)
            PH_00: n = PH_10;
            PH_10: n = PH_11;
            PH_11: n = PH_01;
            PH_01: n = PH_00;
            default: n = PH_00;
        endcase
        return n;
    endfunction

    // A reverse step is a forward step seen from the other side.
    function automatic quad_dir_t quad_dir(quad_phase_t prev, quad_phase_t curr);
        quad_dir_t d;
        if (prev == curr) begin
            d = DIR_NONE;
        end else if (curr == quad_fwd_next(prev)) begin
            d = DIR_FWD;
        end else if (prev == quad_fwd_next(curr)) begin
            d = DIR_REV;
        end else begin
            d = DIR_ILLEGAL;
        end
        return d;
    endfunction

endpackage

// File: rtl/quad_phase_filter.sv
// Synchronizer plus glitch filter for one raw encoder phase.
// The filtered output follows the synchronized input only after FILTER_LEN consecutive differing edges.
module quad_phase_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   filt_q;
    logic                   sampled;

    assign sampled = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (sampled == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // This edge completes the run, so the count can never pass FILTER_LEN-1.
                filt_q <= sampled;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: filters phases A/B and emits one registered up/down pulse per Gray step.
// Define QUAD_STEP_ERR_EN to add the sticky illegal-transition output `err`.
module quad_step_decoder
    import quad_step_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enc_a,
    input  logic enc_b,
    output logic up,
`ifdef QUAD_STEP_ERR_EN
    output logic down,
    output logic err
`else
    output logic down
`endif
);

    logic        a_f;
    logic        b_f;
    quad_phase_t curr;
    quad_phase_t prev_q;
    quad_dir_t   dir;
    logic        moved;
    logic        armed_q;
    logic        up_q;
    logic        down_q;

    quad_phase_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_a (
        .clk (clk),
        .rst (rst),
        .raw (enc_a),
        .filt(a_f)
    );

    quad_phase_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_b (
        .clk (clk),
        .rst (rst),
        .raw (enc_b),
        .filt(b_f)
    );

    assign curr  = {a_f, b_f};
    assign moved = (curr != prev_q);
    assign dir   = quad_dir(prev_q, curr);

    // Until armed, a movement only records the resting position, so a non-00 rest emits nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= PH_00;
            armed_q <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            up_q   <= armed_q && (dir == DIR_FWD);
            down_q <= armed_q && (dir == DIR_REV);
            if (moved) begin
                prev_q  <= curr;
                armed_q <= 1'b1;
            end
        end
    end

    assign up   = up_q;
    assign down = down_q;

`ifdef QUAD_STEP_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (armed_q && (dir == DIR_ILLEGAL)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Quadrature step decoder that turns the two raw phase signals of a rotary encoder into single-cycle `up` / `down` step pulses. It sits directly upstream of the 4-bit up/down counter and drives that counter's `Up` and `Down` inputs. It synchronizes and glitch-filters both phases, then tracks the Gray-code phase sequence. Every legal transition produces exactly one pulse (x4 decoding).

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per phase input. Legal range 2..3.
- `FILTER_LEN`, default 4: consecutive cycles a synchronized phase must differ from its filtered value before the filtered value updates. Legal range 1..16.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enc_a` in 1: raw phase A, asynchronous to `clk`.
- `enc_b` in 1: raw phase B, asynchronous to `clk`.
- `up` out 1: one-cycle pulse for each forward step. Wires to the counter's `Up`.
- `down` out 1: one-cycle pulse for each reverse step. Wires to the counter's `Down`.
- `err` out 1: sticky illegal-transition flag. Present only with `QUAD_STEP_ERR_EN`.

## Operation
- **Reset:** while `rst` is high at a clock edge, all of the following clear to 0: synchronizer flops, filter counters, filtered phases `a_f`/`b_f`, previous phases, the `armed` flag, `up`, `down` and `err`.
- **Synchronizer:** each phase passes through `SYNC_STAGES` flops, giving `a_s`/`b_s`.
- **Filter (per phase):**
  - If `a_s == a_f`, the counter clears.
  - Otherwise the counter increments.
  - When `a_s` has differed for `FILTER_LEN` consecutive edges, `a_f` takes `a_s` at that edge and the counter clears.
  - The counter width is `$clog2(FILTER_LEN+1)`; it never wraps.
- **Decoder state:** `{a_f, b_f}` is compared with its registered previous value `{a_p, b_p}`.
  - Forward sequence, {A,B}: 00→10→11→01→00. Each forward transition registers `up`=1 for one cycle.
  - Reverse sequence: 00→01→11→10→00. Each reverse transition registers `down`=1 for one cycle.
  - No change: both outputs 0.
  - Both bits change in the same cycle (00↔11, 10↔01): illegal. No pulse; `err` sets if compiled in.
- **Invariant:** `up` and `down` are never high in the same cycle.
- **Arming:** the first change of `{a_f, b_f}` after reset initializes `{a_p, b_p}` without emitting a pulse or error, and sets `armed`. This prevents a spurious step when the encoder rests at a non-00 position. `armed` stays set until `rst`.
- **Reset mid-operation:** reset discards any partial filter count and any pending pulse. The cycle after `rst` deasserts, both outputs are 0.
- **Step rate:** the maximum is one step per `FILTER_LEN+1` cycles per phase. Faster phase activity is filtered away as glitches.

## Timing
- **Latency:** a phase change sampled at edge 0 and held stable gives `a_s` updated after edge `SYNC_STAGES-1`. `a_f` updates at edge `SYNC_STAGES-1+FILTER_LEN`, and the pulse is high during the cycle after edge `SYNC_STAGES+FILTER_LEN`. With defaults, that is the cycle following edge 6.
- **Pulse width:** exactly one `clk` cycle; outputs are registered, not combinational.
- **`err`:** rises in the same cycle an illegal pulse would have appeared and holds until `rst`.
- **Glitches:** any phase excursion shorter than `FILTER_LEN` cycles at the synchronizer output produces no output activity.

## Configuration
- **`QUAD_STEP_ERR_EN` defined:** the `err` port and its sticky flop exist; illegal transitions set `err`.
- **Not defined:** there is no `err` port. Illegal transitions are silently dropped: no pulse, and `{a_p, b_p}` still updates.

## Structure
- **Package `quad_step_pkg`:**
  - typedef `quad_phase_t` (2-bit {A,B});
  - constants for the four Gray states;
  - function `quad_dir(prev, curr)` returning NONE / FWD / REV / ILLEGAL.
- **Sub-module `quad_phase_filter`:** synchronizer plus glitch filter for one phase, parameterized by `SYNC_STAGES` and `FILTER_LEN`. It is instantiated twice. The decoder, arming logic and `err` live in the top level.

## Test plan
Defaults apply unless a scenario states otherwise.
1. **Reset:** hold `rst`=1 for 3 cycles with `enc_a`=`enc_b`=0 → `up`=`down`=`err`=0 throughout and after release.
2. **Forward steps:** arm with a 00→10 step, then drive 10→11→01→00, each state held 12 cycles → exactly 4 `up` pulses, each 1 cycle wide, each 7 cycles after the phase change. A chained counter reads 4'h4.
3. **Reverse steps:** from 00 (armed), drive 01→11→10→00 → 4 `down` pulses and no `up`. A chained counter starting at 4'h4 reads 4'h0.
4. **Glitch rejection:** pulse `enc_a` high for 3 cycles with `FILTER_LEN`=4 → no pulse and no `err`. With `FILTER_LEN`=2, the same stimulus → one `up` followed by one `down`.
5. **Illegal transition (macro on):** armed at 00, toggle `enc_a` and `enc_b` together to 11 → no pulse, `err`=1 seven cycles later, `err` held until `rst`. With the macro off → no pulse and no `err` port.
6. **Non-zero start:** hold `enc_a`=`enc_b`=1 through reset release → no pulse and no `err` when the filters settle. Then drive 11→01 → one `up` pulse.
